// File: rtl/rrf_alloc_pkg.sv
// Shared rename-register constants for the dispatch stage, plus the pointer-width macro.
// Pointers carry one extra phase bit above the RRF index so that full and empty can be told apart.
`ifndef RRF_ALLOC_PKG_SV
`define RRF_ALLOC_PKG_SV

package rrf_alloc_pkg;

   localparam int RRF_NUM  = 64;
   localparam int RRF_SEL  = 6;
   localparam int DATA_LEN = 32;

endpackage

`define RRF_PTR_W (rrf_alloc_pkg::RRF_SEL + 1)

`endif

// File: rtl/rrf_alloc.sv
// Rename-register allocator: allocation/commit pointers, free count and dispatch tags.
// Optional RRF_ALLOC_STATS_EN adds stall_cnt_o, a saturating count of capacity-blocked dispatch cycles.
module rrf_alloc
   import rrf_alloc_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     dp1_req_i,
   input  logic                     dp2_req_i,
   input  logic                     stall_dp_i,
   input  logic [1:0]               com_num_i,
   input  logic                     rollback_i,
   input  logic [`RRF_PTR_W-1:0]    rollback_ptr_i,
   output logic                     allocatable_o,
   output logic                     alloc_en1_o,
   output logic                     alloc_en2_o,
   output logic [RRF_SEL-1:0]       rrftag1_o,
   output logic [RRF_SEL-1:0]       rrftag2_o,
   output logic [`RRF_PTR_W-1:0]    rrfptr_o,
   output logic [`RRF_PTR_W-1:0]    comptr_o,
   output logic [`RRF_PTR_W-1:0]    freenum_o
`ifdef RRF_ALLOC_STATS_EN
   ,
   output logic [31:0]              stall_cnt_o
`endif
);

   localparam int                  PTR_W      = `RRF_PTR_W;
   localparam logic [PTR_W-1:0]    RRF_NUM_P  = PTR_W'(RRF_NUM);

   logic [PTR_W-1:0] r_rrfptr;
   logic [PTR_W-1:0] r_comptr;
   logic [PTR_W-1:0] r_freenum;

   logic [1:0]       w_reqnum;
   logic [PTR_W-1:0] w_reqnum_ext;
   logic [PTR_W-1:0] w_com_ext;
   logic [PTR_W-1:0] w_alloc_num;
   logic [PTR_W-1:0] w_comptr_next;
   logic [PTR_W-1:0] w_tag2_ptr;
   logic             w_allocatable;
   logic             w_fire;

   assign w_reqnum      = {1'b0, dp1_req_i} + {1'b0, dp2_req_i};
   assign w_reqnum_ext  = {{(PTR_W-2){1'b0}}, w_reqnum};
   assign w_com_ext     = {{(PTR_W-2){1'b0}}, com_num_i};
   assign w_allocatable = (r_freenum >= w_reqnum_ext);

   // All-or-nothing: with room for only one of two requests, neither slot fires.
   assign w_fire        = w_allocatable & ~stall_dp_i & ~rollback_i & (w_reqnum != 2'd0);
   assign w_alloc_num   = w_fire ? w_reqnum_ext : '0;
   assign w_comptr_next = r_comptr + w_com_ext;
   assign w_tag2_ptr    = r_rrfptr + {{(PTR_W-1){1'b0}}, dp1_req_i};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rrfptr  <= '0;
         r_comptr  <= '0;
         r_freenum <= RRF_NUM_P;
      end else if (rollback_i) begin
         // Entries between the surviving commit pointer and the restored pointer stay occupied.
         r_rrfptr  <= rollback_ptr_i;
         r_comptr  <= w_comptr_next;
         r_freenum <= RRF_NUM_P - (rollback_ptr_i - w_comptr_next);
      end else begin
         r_rrfptr  <= r_rrfptr + w_alloc_num;
         r_comptr  <= w_comptr_next;
         r_freenum <= r_freenum + w_com_ext - w_alloc_num;
      end
   end

`ifdef RRF_ALLOC_STATS_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall_ev;

   assign w_stall_ev = (w_reqnum != 2'd0) & ~stall_dp_i & ~rollback_i & ~w_allocatable;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall_ev && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

   assign allocatable_o = w_allocatable;
   assign alloc_en1_o   = w_fire & dp1_req_i;
   assign alloc_en2_o   = w_fire & dp2_req_i;
   assign rrftag1_o     = r_rrfptr[RRF_SEL-1:0];
   assign rrftag2_o     = w_tag2_ptr[RRF_SEL-1:0];
   assign rrfptr_o      = r_rrfptr;
   assign comptr_o      = r_comptr;
   assign freenum_o     = r_freenum;

endmodule

// File: tb/tb_rrf_alloc.sv
// Directed bench for rrf_alloc: the driver queues hand-computed per-cycle outputs, a negedge monitor compares.
// Expected vector layout: {allocatable, en1, en2, tag1[5:0], tag2[5:0], rrfptr[6:0], comptr[6:0], freenum[6:0]}.
module tb_rrf_alloc;
  import rrf_alloc_pkg::*;

  localparam int W = 36;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       dp1_req_i, dp2_req_i, stall_dp_i, rollback_i;
  logic [1:0] com_num_i;
  logic [6:0] rollback_ptr_i;
  logic       allocatable_o, alloc_en1_o, alloc_en2_o;
  logic [5:0] rrftag1_o, rrftag2_o;
  logic [6:0] rrfptr_o, comptr_o, freenum_o;
`ifdef RRF_ALLOC_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  logic [W-1:0] exp_q[$];
  logic         mon_chk = 1'b0;
  int           vec_id  = 0;
  int           n_cmp   = 0;
  int           n_bad   = 0;

  rrf_alloc dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .dp1_req_i      (dp1_req_i),
    .dp2_req_i      (dp2_req_i),
    .stall_dp_i     (stall_dp_i),
    .com_num_i      (com_num_i),
    .rollback_i     (rollback_i),
    .rollback_ptr_i (rollback_ptr_i),
    .allocatable_o  (allocatable_o),
    .alloc_en1_o    (alloc_en1_o),
    .alloc_en2_o    (alloc_en2_o),
    .rrftag1_o      (rrftag1_o),
    .rrftag2_o      (rrftag2_o),
    .rrfptr_o       (rrfptr_o),
    .comptr_o       (comptr_o),
    .freenum_o      (freenum_o)
`ifdef RRF_ALLOC_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  // clock
  always #5 clk_i = ~clk_i;

  // monitor / scoreboard
  always @(negedge clk_i) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (mon_chk) begin
      act = {allocatable_o, alloc_en1_o, alloc_en2_o, rrftag1_o, rrftag2_o,
             rrfptr_o, comptr_o, freenum_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL vec%0d no_expectation actual=%h", vec_id, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL vec%0d outputs actual a/e1/e2=%b%b%b tags=%0d,%0d rrf=%0d com=%0d free=%0d required a/e1/e2=%b%b%b tags=%0d,%0d rrf=%0d com=%0d free=%0d",
                   vec_id, act[35], act[34], act[33], act[32:27], act[26:21], act[20:14], act[13:7], act[6:0],
                   exp[35], exp[34], exp[33], exp[32:27], exp[26:21], exp[20:14], exp[13:7], exp[6:0]);
        end
      end
    end
  end

  // driver: one cycle of stimulus with its expected outputs for that cycle
  task automatic cyc(input logic d1, input logic d2, input logic st, input logic [1:0] cn,
                     input logic rb, input logic [6:0] rbp,
                     input logic a, input logic e1, input logic e2,
                     input logic [5:0] t1, input logic [5:0] t2,
                     input logic [6:0] rp, input logic [6:0] cp, input logic [6:0] fn);
    dp1_req_i      = d1;
    dp2_req_i      = d2;
    stall_dp_i     = st;
    com_num_i      = cn;
    rollback_i     = rb;
    rollback_ptr_i = rbp;
    if ({5'd0, cn} > (7'd64 - fn)) begin
      n_bad++;
      $display("FAIL vec%0d illegal_commit com_num=%0d occupied=%0d", vec_id + 1, cn, 7'd64 - fn);
    end
    exp_q.push_back({a, e1, e2, t1, t2, rp, cp, fn});
    vec_id++;
    mon_chk = 1'b1;
    @(posedge clk_i);
    #1;
    mon_chk = 1'b0;
  endtask

`ifdef RRF_ALLOC_STATS_EN
  task automatic chk_stats(input logic [31:0] e);
    n_cmp++;
    if (stall_cnt_o !== e) begin
      n_bad++;
      $display("FAIL stall_cnt actual=%0d required=%0d", stall_cnt_o, e);
    end
  endtask
`endif

  initial begin
    reset_i = 1'b1;
    dp1_req_i = 1'b0; dp2_req_i = 1'b0; stall_dp_i = 1'b0;
    com_num_i = 2'd0; rollback_i = 1'b0; rollback_ptr_i = 7'd0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // reset state, first two-slot dispatch
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd0, 6'd0, 7'd0, 7'd0, 7'd64);
    cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'd0, 6'd1, 7'd0, 7'd0, 7'd64);
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd2, 6'd2, 7'd2, 7'd0, 7'd62);
    // fill up to 63 entries
    for (int k = 0; k < 30; k++)
      cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'(2+2*k), 6'(3+2*k), 7'(2+2*k), 7'd0, 7'(62-2*k));
    cyc(1,0,0,2'd0,0,7'd0, 1,1,0, 6'd62, 6'd63, 7'd62, 7'd0, 7'd2);
    // one free, two requests: nothing fires
    cyc(1,1,0,2'd0,0,7'd0, 0,0,0, 6'd63, 6'd0, 7'd63, 7'd0, 7'd1);
    cyc(1,1,0,2'd1,0,7'd0, 0,0,0, 6'd63, 6'd0, 7'd63, 7'd0, 7'd1);
    // wrap: tags 63,0 and phase bit toggles
    cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'd63, 6'd0, 7'd63, 7'd1, 7'd2);
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd1, 6'd1, 7'd65, 7'd1, 7'd0);
    cyc(1,0,0,2'd0,0,7'd0, 0,0,0, 6'd1, 6'd2, 7'd65, 7'd1, 7'd0);
`ifdef RRF_ALLOC_STATS_EN
    chk_stats(32'd3);
`endif

    // reset mid-operation with busy inputs
    dp1_req_i = 1'b1; dp2_req_i = 1'b1; com_num_i = 2'd1;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
`ifdef RRF_ALLOC_STATS_EN
    chk_stats(32'd0);
`endif
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd0, 6'd0, 7'd0, 7'd0, 7'd64);
    cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'd0, 6'd1, 7'd0, 7'd0, 7'd64);
    cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'd2, 6'd3, 7'd2, 7'd0, 7'd62);
    cyc(1,0,0,2'd0,0,7'd0, 1,1,0, 6'd4, 6'd5, 7'd4, 7'd0, 7'd60);
    // slot 2 alone takes the pointer value
    cyc(0,1,0,2'd0,0,7'd0, 1,0,1, 6'd5, 6'd5, 7'd5, 7'd0, 7'd59);
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd6, 6'd6, 7'd6, 7'd0, 7'd58);
    for (int k = 0; k < 9; k++)
      cyc(1,1,0,2'd0,0,7'd0, 1,1,1, 6'(6+2*k), 6'(7+2*k), 7'(6+2*k), 7'd0, 7'(58-2*k));
    // simultaneous alloc 2 and commit 2 at freenum 40
    cyc(1,1,0,2'd2,0,7'd0, 1,1,1, 6'd24, 6'd25, 7'd24, 7'd0, 7'd40);
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd26, 6'd26, 7'd26, 7'd2, 7'd40);
    cyc(1,1,0,2'd2,0,7'd0, 1,1,1, 6'd26, 6'd27, 7'd26, 7'd2, 7'd40);
    cyc(1,1,0,2'd2,0,7'd0, 1,1,1, 6'd28, 6'd29, 7'd28, 7'd4, 7'd40);
    cyc(0,0,0,2'd2,0,7'd0, 1,0,0, 6'd30, 6'd30, 7'd30, 7'd6, 7'd40);
    cyc(0,0,0,2'd2,0,7'd0, 1,0,0, 6'd30, 6'd30, 7'd30, 7'd8, 7'd42);
    // rollback beats allocation, commit still honoured
    cyc(1,1,0,2'd1,1,7'd15, 1,0,0, 6'd30, 6'd31, 7'd30, 7'd10, 7'd44);
    cyc(0,0,0,2'd2,0,7'd0, 1,0,0, 6'd15, 6'd15, 7'd15, 7'd11, 7'd60);
    cyc(0,0,0,2'd2,0,7'd0, 1,0,0, 6'd15, 6'd15, 7'd15, 7'd13, 7'd62);
    // downstream stall with an empty RRF
    cyc(1,1,1,2'd0,0,7'd0, 1,0,0, 6'd15, 6'd16, 7'd15, 7'd15, 7'd64);
    cyc(0,0,0,2'd0,0,7'd0, 1,0,0, 6'd15, 6'd15, 7'd15, 7'd15, 7'd64);
`ifdef RRF_ALLOC_STATS_EN
    chk_stats(32'd0);
`endif

    @(posedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
